// File: rtl/regfile_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_master_pkg
// Brief    : Shared constants, op codes and state encoding for regfile_master.
//            REGFILE_MASTER_VERIFY_EN adds the write-verify state.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_master_pkg;

    localparam int DATA_W = 4;
    localparam int ADDR_W = 3;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_FILL = 3'd3,
        ST_RESP = 3'd4
`ifdef REGFILE_MASTER_VERIFY_EN
        ,
        ST_VFY  = 3'd5
`endif
    } state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_addr_counter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_addr_counter
// Brief    : ADDR_W-bit up-counter with clear/enable and terminal-count flag,
//            used to sweep every regfile address during FILL.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_addr_counter #(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              a_reset,
    input  logic              i_clr,
    input  logic              i_en,
    output logic [ADDR_W-1:0] o_count,
    output logic              o_tc
);

    logic [ADDR_W-1:0] r_count;

    // Count up when enabled; clear has priority; wraps naturally at the top.
    always_ff @(posedge clk or negedge a_reset) begin
        if (!a_reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = &r_count;

endmodule
`default_nettype wire

// File: rtl/regfile_master.sv
`default_nettype none
// ============================================================================
// Module   : regfile_master
// Brief    : Command initiator for an 8 x 4-bit register file. Executes WRITE,
//            READ and FILL commands one at a time and returns read data on a
//            valid/ready response channel.
//            Optional macro REGFILE_MASTER_VERIFY_EN: read back after every
//            WRITE and raise a sticky err on mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_master
    import regfile_master_pkg::*;
#(
    parameter int DATA_W = regfile_master_pkg::DATA_W,
    parameter int ADDR_W = regfile_master_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              a_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_a,
    output logic [DATA_W-1:0] rf_d,
    input  logic [DATA_W-1:0] rf_q,
    output logic              busy,
    output logic              err
);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt;
    logic              r_rf_we, w_rf_we_nxt;
    logic [ADDR_W-1:0] r_rf_a, w_rf_a_nxt;
    logic [DATA_W-1:0] r_rf_d, w_rf_d_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0] r_rsp_data, w_rsp_data_nxt;
    logic [ADDR_W-1:0] r_rsp_addr, w_rsp_addr_nxt;
    logic              w_cnt_clr, w_cnt_en, w_cnt_tc;
    logic [ADDR_W-1:0] w_cnt;
`ifdef REGFILE_MASTER_VERIFY_EN
    logic              r_err, w_err_nxt;
`endif

    regfile_addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_fill_cnt (
        .clk     (clk),
        .a_reset (a_reset),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (w_cnt),
        .o_tc    (w_cnt_tc)
    );

    // Next-state and next-output logic; write enable defaults low so only WR/FILL drive it.
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_data_nxt      = r_data;
        w_rf_we_nxt     = 1'b0;
        w_rf_a_nxt      = r_rf_a;
        w_rf_d_nxt      = r_rf_d;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_addr_nxt  = r_rsp_addr;
        w_cnt_clr       = 1'b0;
        w_cnt_en        = 1'b0;
`ifdef REGFILE_MASTER_VERIFY_EN
        w_err_nxt       = r_err;
`endif
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_addr_nxt = cmd_addr;
                    w_data_nxt = cmd_data;
                    case (cmd_op)
                        OP_WRITE: begin
                            w_state_nxt = ST_WR;
                            w_rf_we_nxt = 1'b1;
                            w_rf_a_nxt  = cmd_addr;
                            w_rf_d_nxt  = cmd_data;
                        end
                        OP_READ: begin
                            w_state_nxt = ST_RD;
                            w_rf_a_nxt  = cmd_addr;
                        end
                        OP_FILL: begin
                            w_state_nxt = ST_FILL;
                            w_rf_we_nxt = 1'b1;
                            w_rf_a_nxt  = '0;
                            w_rf_d_nxt  = cmd_data;
                            w_cnt_clr   = 1'b1;
                        end
                        default: begin
                            // Reserved op: consumed without side effects.
                            w_state_nxt = ST_IDLE;
                        end
                    endcase
                end
            end
            ST_WR: begin
`ifdef REGFILE_MASTER_VERIFY_EN
                // Hold rf_a on the written address so rf_q reflects it next cycle.
                w_state_nxt = ST_VFY;
`else
                w_state_nxt = ST_IDLE;
`endif
            end
`ifdef REGFILE_MASTER_VERIFY_EN
            ST_VFY: begin
                w_state_nxt = ST_IDLE;
                if (rf_q != r_data) begin
                    w_err_nxt = 1'b1;
                end
            end
`endif
            ST_RD: begin
                w_state_nxt     = ST_RESP;
                w_rsp_valid_nxt = 1'b1;
                w_rsp_data_nxt  = rf_q;
                w_rsp_addr_nxt  = r_addr;
            end
            ST_FILL: begin
                if (w_cnt_tc) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_clr   = 1'b1;
                end else begin
                    w_rf_we_nxt = 1'b1;
                    w_rf_a_nxt  = w_cnt + 1'b1;
                    w_cnt_en    = 1'b1;
                end
            end
            ST_RESP: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge a_reset) begin
        if (!a_reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_data      <= '0;
            r_rf_we     <= 1'b0;
            r_rf_a      <= '0;
            r_rf_d      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_addr  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_data      <= w_data_nxt;
            r_rf_we     <= w_rf_we_nxt;
            r_rf_a      <= w_rf_a_nxt;
            r_rf_d      <= w_rf_d_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_addr  <= w_rsp_addr_nxt;
        end
    end

`ifdef REGFILE_MASTER_VERIFY_EN
    // Sticky readback-mismatch flag, cleared only by reset.
    always_ff @(posedge clk or negedge a_reset) begin
        if (!a_reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
        end
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign rf_we     = r_rf_we;
    assign rf_a      = r_rf_a;
    assign rf_d      = r_rf_d;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_addr  = r_rsp_addr;

endmodule
`default_nettype wire

// File: tb/tb_regfile_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_master
// Brief    : Self-checking bench for regfile_master with a behavioural 8x4
//            regfile and a response scoreboard. Honours REGFILE_MASTER_VERIFY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_master;

    logic       clk = 1'b0;
    logic       a_reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_addr;
    logic [3:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic [2:0] rsp_addr;
    logic       rf_we;
    logic [2:0] rf_a;
    logic [3:0] rf_d;
    logic [3:0] rf_q;
    logic       busy;
    logic       err;

    typedef struct packed {
        logic [2:0] a;
        logic [3:0] d;
    } rsp_t;

    logic [3:0] mem    [8];
    logic [3:0] shadow [8];
    logic       stuck = 1'b0;
    rsp_t       exp_q  [$];
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    // Behavioural regfile: synchronous write, combinational read, optional stuck bit 0.
    always @(posedge clk) begin
        if (rf_we) mem[rf_a] <= rf_d;
    end
    assign rf_q = mem[rf_a] & (stuck ? 4'hE : 4'hF);

    regfile_master u_dut (
        .clk       (clk),
        .a_reset   (a_reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .rf_we     (rf_we),
        .rf_a      (rf_a),
        .rf_d      (rf_d),
        .rf_q      (rf_q),
        .busy      (busy),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a command at a negedge, hold until accepted; returns at the negedge of N+1.
    task automatic send_cmd(input logic [1:0] op, input logic [2:0] a, input logic [3:0] d);
        bit ok = 0;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("cmd_timeout", 32'd0, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [3:0] d);
        send_cmd(2'b00, a, d);
        shadow[a] = d;
        check("wr_we", rf_we, 1);
        check("wr_a", rf_a, a);
        check("wr_d", rf_d, d);
        check("wr_rdy", cmd_ready, 0);
        @(negedge clk);
`ifdef REGFILE_MASTER_VERIFY_EN
        check("vfy_we", rf_we, 0);
        check("vfy_a", rf_a, a);
        check("vfy_rdy", cmd_ready, 0);
        @(negedge clk);
`endif
        check("wr_done_we", rf_we, 0);
        check("wr_done_rdy", cmd_ready, 1);
    endtask

    // Pop the oldest expected response and compare; hold rsp_ready low for 'hold' cycles.
    task automatic collect(input int hold);
        rsp_t e;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check("rsp_data", rsp_data, e.d);
        check("rsp_addr", rsp_addr, e.a);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_data", rsp_data, e.d);
            check("hold_rdy", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_drop", rsp_valid, 0);
        check("rsp_idle", cmd_ready, 1);
    endtask

    task automatic do_read(input logic [2:0] a, input int hold);
        rsp_t e;
        send_cmd(2'b01, a, 4'h0);
        e.a = a;
        e.d = shadow[a];
        exp_q.push_back(e);
        check("rd_we", rf_we, 0);
        check("rd_a", rf_a, a);
        check("rd_early", rsp_valid, 0);
        @(negedge clk);
        check("rd_valid", rsp_valid, 1);
        collect(hold);
    endtask

    // FILL sweep; reset_at < 8 asserts reset in the cycle that count reaches reset_at.
    task automatic do_fill(input logic [3:0] d, input int reset_at);
        send_cmd(2'b10, 3'd0, d);
        for (int k = 0; k < 8; k++) begin
            if (k == reset_at) begin
                a_reset = 1'b0;
                #1;
                check("rst_we", rf_we, 0);
                check("rst_busy", busy, 0);
                check("rst_a", rf_a, 0);
                @(negedge clk);
                a_reset = 1'b1;
                @(negedge clk);
                check("rst_rdy", cmd_ready, 1);
                return;
            end
            check("fill_we", rf_we, 1);
            check("fill_a", rf_a, k);
            check("fill_d", rf_d, d);
            check("fill_rdy", cmd_ready, 0);
            shadow[k] = d;
            @(negedge clk);
        end
        check("fill_end_we", rf_we, 0);
        check("fill_end_rdy", cmd_ready, 1);
        check("fill_end_busy", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            mem[i]    = 4'h0;
            shadow[i] = 4'h0;
        end
        a_reset   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = 3'd0;
        cmd_data  = 4'h0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_we", rf_we, 0);
        check("reset_a", rf_a, 0);
        check("reset_d", rf_d, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_rsp_addr", rsp_addr, 0);
        check("reset_busy", busy, 0);
        check("reset_err", err, 0);
        check("reset_rdy", cmd_ready, 1);
        a_reset = 1'b1;
        @(negedge clk);

        // Write then read back.
        do_write(3'd3, 4'hA);
        do_read(3'd3, 0);

        // Full fill and readback.
        do_fill(4'h5, 8);
        for (int a = 0; a < 8; a++) do_read(3'(a), 0);

        // Back-pressured response.
        do_read(3'd6, 5);

        // Reset in the middle of a fill.
        do_fill(4'hF, 8);
        do_fill(4'h5, 4);
        for (int a = 0; a < 8; a++) do_read(3'(a), 0);

        // Reserved op is dropped.
        send_cmd(2'b11, 3'd2, 4'h7);
        check("rsvd_busy", busy, 0);
        check("rsvd_we", rf_we, 0);
        check("rsvd_rdy", cmd_ready, 1);
        @(negedge clk);
        check("rsvd_rsp", rsp_valid, 0);
        check("rsvd_we2", rf_we, 0);
        do_read(3'd2, 0);

        // Stray rsp_ready while idle is harmless.
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("stray_rsp", rsp_valid, 0);

        // Random writes with readback.
        for (int i = 0; i < 6; i++) begin
            logic [2:0] ra;
            logic [3:0] rd;
            ra = 3'($urandom_range(0, 7));
            rd = 4'($urandom_range(0, 15));
            do_write(ra, rd);
            do_read(ra, int'($urandom_range(0, 2)));
        end
        check("err_clean", err, 0);

        // Stuck-at regfile bit against write verification.
`ifdef REGFILE_MASTER_VERIFY_EN
        stuck = 1'b1;
        do_write(3'd1, 4'h1);
        check("err_set", err, 1);
        repeat (3) @(negedge clk);
        check("err_sticky", err, 1);
`else
        stuck = 1'b1;
        do_write(3'd1, 4'h1);
        check("err_off", err, 0);
        repeat (3) @(negedge clk);
        check("err_off_hold", err, 0);
`endif

        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
